// File: rtl/rv_fetch_unit_if.sv
// rtl/rv_fetch_unit_if.sv - instruction memory request/response interface
interface rv_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/rv_fetch_unit.sv
// rtl/rv_fetch_unit.sv - RV32I instruction fetch and PC sequencer
module rv_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   rv_fetch_unit_if.master   imem,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [4:0]        selector,
   output logic [31:0]       pc,
   output logic [31:0]       pc_plus4,
   input  logic              commit,
   input  logic              PCSrc,
   input  logic [31:0]       target,
   output logic              fault,
   output logic [31:0]       instret
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_EXEC  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] instret_q;
   logic        req_q;
   logic        valid_q;
   logic        fault_q;

   // Sequencer: state plus registered handshake/status flags, so the outputs never glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= NOP;
         instret_q <= 32'd0;
         req_q     <= 1'b1;
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (imem.imem_ready) begin
                  state_q <= S_WAIT;
                  req_q   <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem.imem_rvalid) begin
                  // Only 32-bit encodings (low bits 11) are legal; anything else faults
                  if (imem.imem_rdata[1:0] != 2'b11) begin
                     state_q <= S_FAULT;
                     fault_q <= 1'b1;
                  end else begin
                     instr_q <= imem.imem_rdata;
                     state_q <= S_EXEC;
                     valid_q <= 1'b1;
                  end
               end
            end
            S_EXEC: begin
               if (commit) begin
                  if (PCSrc && (target[1:0] != 2'b00)) begin
                     // Misaligned target: keep pc pointing at the offending instruction
                     state_q <= S_FAULT;
                     valid_q <= 1'b0;
                     fault_q <= 1'b1;
                  end else begin
                     pc_q      <= PCSrc ? target : pc_plus4;
                     instret_q <= instret_q + 32'd1;
                     state_q   <= S_FETCH;
                     valid_q   <= 1'b0;
                     req_q     <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_FAULT;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
               fault_q <= 1'b1;
            end
         endcase
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign instr_valid    = valid_q;
   assign instr          = instr_q;
   assign selector       = instr_q[6:2];
   assign pc             = pc_q;
   assign pc_plus4       = pc_q + 32'd4;
   assign fault          = fault_q;
   assign instret        = instret_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb/tb_rv_fetch_unit.sv - scoreboard testbench for rv_fetch_unit
module tb_rv_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [4:0]  selector;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        commit = 1'b0;
   logic        PCSrc = 1'b0;
   logic [31:0] target = 32'd0;
   logic        fault;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  sel;
      logic [31:0] pc;
      logic [31:0] ir;
   } rec_t;

   logic [31:0] exp_addr[$];
   rec_t        exp_rec[$];

   rv_fetch_unit_if mem ();

   rv_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (mem.master),
      .instr_valid (instr_valid),
      .instr       (instr),
      .selector    (selector),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .commit      (commit),
      .PCSrc       (PCSrc),
      .target      (target),
      .fault       (fault),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares every accepted fetch and every commit against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem.imem_req && mem.imem_ready) begin
            if (exp_addr.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_fetch: got addr %h expected none", mem.imem_addr);
            end else begin
               check("fetch_addr", mem.imem_addr, exp_addr.pop_front());
            end
         end
         if (instr_valid && commit) begin
            if (exp_rec.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_commit: got pc %h expected none", pc);
            end else begin
               rec_t r;
               r = exp_rec.pop_front();
               check("commit_instr", instr, r.instr);
               check("commit_sel", {27'd0, selector}, {27'd0, r.sel});
               check("commit_pc", pc, r.pc);
               check("commit_instret", instret, r.ir);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int rs, input int vs);
      exp_addr.push_back(addr);
      for (int i = 0; i < rs; i++) begin
         mem.imem_ready = 1'b0;
         check("stall_req", {31'd0, mem.imem_req}, 32'd1);
         check("stall_addr", mem.imem_addr, addr);
         tick();
      end
      mem.imem_ready = 1'b1;
      tick();
      mem.imem_ready = 1'b0;
      for (int i = 0; i < vs; i++) begin
         check("wait_req", {31'd0, mem.imem_req}, 32'd0);
         check("wait_valid", {31'd0, instr_valid}, 32'd0);
         tick();
      end
      mem.imem_rvalid = 1'b1;
      mem.imem_rdata  = word;
      tick();
      mem.imem_rvalid = 1'b0;
      mem.imem_rdata  = 32'd0;
   endtask

   task automatic do_commit(input logic src, input logic [31:0] tgt, input logic [31:0] e_instr,
                            input logic [4:0] e_sel, input logic [31:0] e_pc, input logic [31:0] e_ir);
      rec_t r;
      r.instr = e_instr; r.sel = e_sel; r.pc = e_pc; r.ir = e_ir;
      exp_rec.push_back(r);
      check("exec_valid", {31'd0, instr_valid}, 32'd1);
      commit = 1'b1;
      PCSrc  = src;
      target = tgt;
      tick();
      commit = 1'b0;
      PCSrc  = 1'b0;
      target = 32'd0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pc"}, pc, 32'h0000_0100);
      check({tag, "_instr"}, instr, 32'h0000_0013);
      check({tag, "_sel"}, {27'd0, selector}, 32'd4);
      check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      check({tag, "_fault"}, {31'd0, fault}, 32'd0);
      check({tag, "_instret"}, instret, 32'd0);
      check({tag, "_req"}, {31'd0, mem.imem_req}, 32'd1);
      check({tag, "_addr"}, mem.imem_addr, 32'h0000_0100);
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst");
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      mem.imem_ready  = 1'b0;
      mem.imem_rvalid = 1'b0;
      mem.imem_rdata  = 32'd0;
      tick();
      check_reset_vals("por");
      tick();
      rst_n = 1'b1;

      // Back-to-back fastest instruction
      fetch(32'h0000_0100, 32'h0000_0033, 0, 0);
      check("exec_instr", instr, 32'h0000_0033);
      check("exec_sel", {27'd0, selector}, 32'h0000_000C);
      do_commit(1'b0, 32'd0, 32'h0000_0033, 5'h0C, 32'h0000_0100, 32'd0);
      check("instret_1", instret, 32'd1);
      check("next_addr", mem.imem_addr, 32'h0000_0104);

      // Memory stalls, then a taken branch
      fetch(32'h0000_0104, 32'h00A0_0093, 3, 2);
      do_commit(1'b1, 32'h0000_0040, 32'h00A0_0093, 5'h04, 32'h0000_0104, 32'd1);

      // Jump to the last word of the address space
      fetch(32'h0000_0040, 32'h0000_006F, 1, 1);
      do_commit(1'b1, 32'hFFFF_FFFC, 32'h0000_006F, 5'h1B, 32'h0000_0040, 32'd2);

      // pc and instret wrap together
      fetch(32'hFFFF_FFFC, 32'h0000_0033, 0, 0);
      check("top_plus4", pc_plus4, 32'h0000_0000);
      @(negedge clk);
      dut.instret_q = 32'hFFFF_FFFF;
      tick();
      do_commit(1'b0, 32'd0, 32'h0000_0033, 5'h0C, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
      check("instret_wrap", instret, 32'd0);
      check("pc_wrap", mem.imem_addr, 32'h0000_0000);

      // Illegal fetched encoding faults without touching instr
      fetch(32'h0000_0000, 32'h0000_0010, 0, 0);
      check("ifault_fault", {31'd0, fault}, 32'd1);
      check("ifault_valid", {31'd0, instr_valid}, 32'd0);
      check("ifault_instr", instr, 32'h0000_0033);
      check("ifault_pc", pc, 32'h0000_0000);
      check("ifault_req", {31'd0, mem.imem_req}, 32'd0);

      // Misaligned jump target faults with pc and instret held
      do_reset();
      fetch(32'h0000_0100, 32'h0000_0013, 0, 0);
      do_commit(1'b1, 32'h0000_0042, 32'h0000_0013, 5'h04, 32'h0000_0100, 32'd0);
      mem.imem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("tfault_fault", {31'd0, fault}, 32'd1);
         check("tfault_req", {31'd0, mem.imem_req}, 32'd0);
         check("tfault_pc", pc, 32'h0000_0100);
         check("tfault_instret", instret, 32'd0);
         tick();
      end
      mem.imem_ready = 1'b0;

      // Reset during WAIT drops the outstanding response
      do_reset();
      exp_addr.push_back(32'h0000_0100);
      mem.imem_ready = 1'b1;
      tick();
      mem.imem_ready = 1'b0;
      rst_n = 1'b0;
      mem.imem_rvalid = 1'b1;
      mem.imem_rdata  = 32'h0000_0033;
      tick();
      rst_n = 1'b1;
      tick();
      mem.imem_rvalid = 1'b0;
      mem.imem_rdata  = 32'd0;
      check_reset_vals("wrst");
      fetch(32'h0000_0100, 32'h0000_00B3, 0, 0);
      do_commit(1'b0, 32'd0, 32'h0000_00B3, 5'h0C, 32'h0000_0100, 32'd0);
      check("wrst_next", mem.imem_addr, 32'h0000_0104);

      tick();
      check("addr_queue_empty", exp_addr.size(), 32'd0);
      check("rec_queue_empty", exp_rec.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
